// File: rtl/encoder_using_if.sv
// Registered one-hot to binary encoder with enable, valid and error flags.
// Only an exact one-hot input encodes; zero and multi-hot inputs encode to index 0.
module encoder_using_if #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [OUTPUT_LENGTH-1:0] binary_out,
  input  logic [INPUT_LENGTH-1:0]  encoder_in,
  input  logic                     enable,
  output logic                     valid,
  output logic                     error
);

  localparam logic [INPUT_LENGTH-1:0] ONE_C = {{(INPUT_LENGTH-1){1'b0}}, 1'b1};

  logic [OUTPUT_LENGTH-1:0] index_s;
  logic                     hit_s;
  logic                     any_s;
  logic [OUTPUT_LENGTH-1:0] binary_next_s;
  logic                     valid_next_s;
  logic                     error_next_s;
  logic [OUTPUT_LENGTH-1:0] binary_r;
  logic                     valid_r;
  logic                     error_r;

  // Exact-match chain: at most one one-hot constant can equal the input.
  always_comb begin
    index_s = {OUTPUT_LENGTH{1'b0}};
    hit_s   = 1'b0;
    for (int i = 0; i < INPUT_LENGTH; i++) begin
      if (encoder_in == (ONE_C << i)) begin
        index_s = OUTPUT_LENGTH'(i);
        hit_s   = 1'b1;
      end else begin
        index_s = index_s;
        hit_s   = hit_s;
      end
    end
  end

  assign any_s = |encoder_in;

  // Next-value selection; a non-zero input that matched nothing has two or more bits set.
  always_comb begin
    binary_next_s = {OUTPUT_LENGTH{1'b0}};
    valid_next_s  = 1'b0;
    error_next_s  = 1'b0;
    if (!enable) begin
      binary_next_s = {OUTPUT_LENGTH{1'b0}};
      valid_next_s  = 1'b0;
      error_next_s  = 1'b0;
    end else if (hit_s) begin
      binary_next_s = index_s;
      valid_next_s  = 1'b1;
      error_next_s  = 1'b0;
    end else begin
      binary_next_s = {OUTPUT_LENGTH{1'b0}};
      valid_next_s  = 1'b0;
      error_next_s  = any_s;
    end
  end

  // Output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_r <= {OUTPUT_LENGTH{1'b0}};
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      binary_r <= binary_next_s;
      valid_r  <= valid_next_s;
      error_r  <= error_next_s;
    end
  end

  assign binary_out = binary_r;
  assign valid      = valid_r;
  assign error      = error_r;

endmodule

// File: tb/tb_encoder_using_if.sv
// Scoreboard bench for encoder_using_if: directed sweeps plus random traffic,
// expected results from a popcount-based reference model.
module tb_encoder_using_if;

  localparam int IL = 16;
  localparam int OL = 4;

  logic          clk;
  logic          rst;
  logic [OL-1:0] binary_out;
  logic [IL-1:0] encoder_in;
  logic          enable;
  logic          valid;
  logic          error;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [OL-1:0] bin;
    logic          vld;
    logic          err;
  } resp_t;

  resp_t exp_q[$];

  encoder_using_if #(.INPUT_LENGTH(IL), .OUTPUT_LENGTH(OL)) dut (
    .clk        (clk),
    .rst        (rst),
    .binary_out (binary_out),
    .encoder_in (encoder_in),
    .enable     (enable),
    .valid      (valid),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic resp_t model(input logic en, input logic [IL-1:0] vec);
    resp_t r;
    int    ones;
    r    = '0;
    ones = $countones(vec);
    if (en && ones == 1) begin
      for (int k = 0; k < IL; k++) if (vec[k]) r.bin = OL'(k);
      r.vld = 1'b1;
    end else if (en && ones >= 2) begin
      r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input resp_t exp);
    n_checks++;
    if (binary_out !== exp.bin || valid !== exp.vld || error !== exp.err) begin
      n_fail++;
      $display("FAIL %s: got bin=%0d valid=%b error=%b, expected bin=%0d valid=%b error=%b",
               name, binary_out, valid, error, exp.bin, exp.vld, exp.err);
    end
  endtask

  // Drive one input vector for the next clock edge and record its expected response.
  task automatic step(input logic en, input logic [IL-1:0] vec);
    @(negedge clk);
    enable     = en;
    encoder_in = vec;
    exp_q.push_back(model(en, vec));
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: the DUT presents a new result after every non-reset edge.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scoreboard", e);
      end
    end
  end

  initial begin
    logic [IL-1:0] v;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    enable     = 1'b1;
    encoder_in = 16'h8000;
    #3;
    check("reset_async", '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", '0);

    // Release reset with 0x8000 enabled: first edge gives index 15.
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model(1'b1, 16'h8000));

    // Disabled sweep.
    step(1'b0, 16'h0000);
    for (int i = 1; i < IL; i++) step(1'b0, 16'h0001 << i);

    // Enabled sweep.
    for (int i = 0; i < IL; i++) step(1'b1, 16'h0001 << i);

    // Zero input then index 0.
    step(1'b1, 16'h0000);
    step(1'b1, 16'h0001);

    // Multi-hot.
    step(1'b1, 16'h0006);
    step(1'b1, 16'h8001);
    step(1'b0, 16'h0006);
    step(1'b1, 16'hFFFF);

    // Enable toggle with a held input.
    step(1'b0, 16'h0400);
    step(1'b1, 16'h0400);
    step(1'b0, 16'h0400);

    // Random traffic biased towards one-hot, zero and multi-hot cases.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'h0001 << $urandom_range(0, IL - 1);
        1:       v = 16'h0000;
        2:       v = (16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7));
        default: v = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), v);
    end
    drain();

    // Mid-stream asynchronous reset.
    step(1'b1, 16'h8000);
    drain();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_midstream", '0);
    @(posedge clk);
    #2;
    check("reset_midstream_hold", '0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model(1'b1, 16'h8000));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
